// File: rtl/mips_mc_controller.sv
// ============================================================================
// Module  : mips_mc_controller
// Brief   : Multicycle MIPS control FSM with memory-ready wait handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inst_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic             alusrca_o,
    output logic             memtoreg_o,
    output logic             iord_o,
    output logic             regdst_o,
    output logic             pcen_o,
    output logic             regwrite_o,
    output logic             irwrite_o,
    output logic [1:0]       pcsource_o,
    output logic [1:0]       alusrcb_o,
    output logic [2:0]       alucont_o,
    output logic             illegal_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_LWRD   = 4'd3,
        S_LWWB   = 4'd4,
        S_SWWR   = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEX    = 4'd8,
        S_AEX    = 4'd9,
        S_AWB    = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;
    logic       w_unused_inst;

    assign w_op          = inst_i[WIDTH-1 -: 6];
    assign w_funct       = inst_i[5:0];
    assign w_unused_inst = ^inst_i[WIDTH-7:6];

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = 3'b010;
        case (w_funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode the state register; the rst gate forces everything
    // (alucont included) to zero while reset is held.
    always_comb begin
        w_next     = S_FETCH;
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        alusrca_o  = 1'b0;
        memtoreg_o = 1'b0;
        iord_o     = 1'b0;
        regdst_o   = 1'b0;
        pcen_o     = 1'b0;
        regwrite_o = 1'b0;
        irwrite_o  = 1'b0;
        pcsource_o = 2'b00;
        alusrcb_o  = 2'b00;
        alucont_o  = 3'b010;
        illegal_o  = 1'b0;
        state_o    = r_state;
        case (r_state)
            S_FETCH: begin
                memread_o = 1'b1;
                alusrcb_o = 2'b01;
                irwrite_o = mem_ready_i;
                pcen_o    = mem_ready_i;
                w_next    = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb_o = 2'b11;
                case (w_op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_ADDI:        w_next = S_AEX;
                    c_OP_BEQ:         w_next = S_BEX;
                    c_OP_J:           w_next = S_JEX;
                    c_OP_R: begin
                        w_next    = w_funct_ok ? S_REX : S_FETCH;
                        illegal_o = ~w_funct_ok;
                    end
                    default:          illegal_o = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                w_next    = (w_op == c_OP_SW) ? S_SWWR : S_LWRD;
            end
            S_LWRD: begin
                iord_o    = 1'b1;
                memread_o = 1'b1;
                w_next    = mem_ready_i ? S_LWWB : S_LWRD;
            end
            S_LWWB: begin
                regwrite_o = 1'b1;
                memtoreg_o = 1'b1;
            end
            S_SWWR: begin
                iord_o     = 1'b1;
                memwrite_o = 1'b1;
                w_next     = mem_ready_i ? S_FETCH : S_SWWR;
            end
            S_REX: begin
                alusrca_o = 1'b1;
                alucont_o = w_funct_alu;
                w_next    = S_RWB;
            end
            S_RWB: begin
                regwrite_o = 1'b1;
                regdst_o   = 1'b1;
            end
            S_BEX: begin
                alusrca_o  = 1'b1;
                alucont_o  = 3'b110;
                pcsource_o = 2'b01;
                pcen_o     = zero_i;
            end
            S_AEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                w_next    = S_AWB;
            end
            S_AWB: begin
                regwrite_o = 1'b1;
            end
            S_JEX: begin
                pcsource_o = 2'b10;
                pcen_o     = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (!rst) begin
            memread_o  = 1'b0;
            memwrite_o = 1'b0;
            alusrca_o  = 1'b0;
            memtoreg_o = 1'b0;
            iord_o     = 1'b0;
            regdst_o   = 1'b0;
            pcen_o     = 1'b0;
            regwrite_o = 1'b0;
            irwrite_o  = 1'b0;
            pcsource_o = 2'b00;
            alusrcb_o  = 2'b00;
            alucont_o  = 3'b000;
            illegal_o  = 1'b0;
            state_o    = 4'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
// ============================================================================
// Module  : tb_mips_mc_controller
// Brief   : Scoreboard bench for mips_mc_controller using directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       regdst;
        logic       pcen;
        logic       regwrite;
        logic       irwrite;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [2:0] alucont;
        logic       illegal;
    } out_t;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i;
    logic        zero_i;
    logic        mem_ready_i;
    out_t        w_act;

    int   n_checks;
    int   n_errors;
    int   n_step;
    out_t q_exp[$];
    int   q_id[$];

    mips_mc_controller #(.WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .memread_o   (w_act.memread),
        .memwrite_o  (w_act.memwrite),
        .alusrca_o   (w_act.alusrca),
        .memtoreg_o  (w_act.memtoreg),
        .iord_o      (w_act.iord),
        .regdst_o    (w_act.regdst),
        .pcen_o      (w_act.pcen),
        .regwrite_o  (w_act.regwrite),
        .irwrite_o   (w_act.irwrite),
        .pcsource_o  (w_act.pcsource),
        .alusrcb_o   (w_act.alusrcb),
        .alucont_o   (w_act.alucont),
        .illegal_o   (w_act.illegal),
        .state_o     (w_act.st)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-written expected outputs for each state, Mealy bits supplied by caller.
    function automatic out_t e(input int s, input logic pcen, input logic irw,
                               input logic ill, input logic [2:0] alu);
        out_t o;
        o         = '0;
        o.st      = 4'(s);
        o.pcen    = pcen;
        o.irwrite = irw;
        o.illegal = ill;
        o.alucont = alu;
        case (s)
            0:  begin o.memread = 1'b1; o.alusrcb = 2'b01; end
            1:  o.alusrcb = 2'b11;
            2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            3:  begin o.iord = 1'b1; o.memread = 1'b1; end
            4:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            6:  o.alusrca = 1'b1;
            7:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
            8:  begin o.alusrca = 1'b1; o.pcsource = 2'b01; end
            9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            10: o.regwrite = 1'b1;
            11: o.pcsource = 2'b10;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic out_t es(input int s);
        return e(s, 1'b0, 1'b0, 1'b0, 3'b010);
    endfunction

    task automatic step(input logic r, input logic [31:0] ins, input logic z,
                        input logic rdy, input out_t exp);
        @(posedge clk);
        #1;
        rst         = r;
        inst_i      = ins;
        zero_i      = z;
        mem_ready_i = rdy;
        n_step++;
        q_exp.push_back(exp);
        q_id.push_back(n_step);
    endtask

    initial begin : monitor
        out_t xp;
        int   id;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                xp = q_exp.pop_front();
                id = q_id.pop_front();
                n_checks++;
                if (w_act !== xp) begin
                    n_errors++;
                    $display("FAIL step%0d outputs: got %h required %h (state got %0d required %0d)",
                             id, w_act, xp, w_act.st, xp.st);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] add_i, lw_i, sw_i, beq_i, j_i, addi_i, bad_op, bad_fn;
        int   wait_cyc;
        out_t zr;
        zr          = '0;
        add_i       = 32'h0022_1820;
        lw_i        = 32'h8C22_0004;
        sw_i        = 32'hAC22_0004;
        beq_i       = 32'h1022_0003;
        j_i         = 32'h0800_0010;
        addi_i      = 32'h2022_0005;
        bad_op      = 32'hFC00_0000;
        bad_fn      = 32'h0022_1807;
        n_checks    = 0;
        n_errors    = 0;
        n_step      = 0;
        rst         = 1'b0;
        inst_i      = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;

        step(1'b0, '0, 1'b0, 1'b0, zr);
        step(1'b1, '0, 1'b0, 1'b0, es(0));

        // add, ready ignored in REX
        step(1'b1, add_i, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, add_i, 1'b0, 1'b1, es(1));
        step(1'b1, add_i, 1'b0, 1'b0, es(6));
        step(1'b1, add_i, 1'b0, 1'b1, es(7));

        // lw with two wait cycles in LWRD
        step(1'b1, lw_i, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, lw_i, 1'b0, 1'b1, es(1));
        step(1'b1, lw_i, 1'b0, 1'b1, es(2));
        step(1'b1, lw_i, 1'b0, 1'b0, es(3));
        step(1'b1, lw_i, 1'b0, 1'b0, es(3));
        step(1'b1, lw_i, 1'b0, 1'b1, es(3));
        step(1'b1, lw_i, 1'b0, 1'b1, es(4));

        // sw with one fetch wait and one store wait
        step(1'b1, sw_i, 1'b0, 1'b0, es(0));
        step(1'b1, sw_i, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, sw_i, 1'b0, 1'b1, es(1));
        step(1'b1, sw_i, 1'b0, 1'b1, es(2));
        step(1'b1, sw_i, 1'b0, 1'b0, es(5));
        step(1'b1, sw_i, 1'b0, 1'b1, es(5));

        // beq taken and not taken
        step(1'b1, beq_i, 1'b1, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, beq_i, 1'b1, 1'b1, es(1));
        step(1'b1, beq_i, 1'b1, 1'b1, e(8, 1'b1, 1'b0, 1'b0, 3'b110));
        step(1'b1, beq_i, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, beq_i, 1'b0, 1'b1, es(1));
        step(1'b1, beq_i, 1'b0, 1'b1, e(8, 1'b0, 1'b0, 1'b0, 3'b110));

        // jump
        step(1'b1, j_i, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, j_i, 1'b0, 1'b1, es(1));
        step(1'b1, j_i, 1'b0, 1'b1, e(11, 1'b1, 1'b0, 1'b0, 3'b010));

        // addi
        step(1'b1, addi_i, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, addi_i, 1'b0, 1'b1, es(1));
        step(1'b1, addi_i, 1'b0, 1'b1, es(9));
        step(1'b1, addi_i, 1'b0, 1'b1, es(10));

        // illegal opcode, then illegal funct; each returns to FETCH
        step(1'b1, bad_op, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, bad_op, 1'b0, 1'b1, e(1, 1'b0, 1'b0, 1'b1, 3'b010));
        step(1'b1, bad_fn, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, bad_fn, 1'b0, 1'b1, e(1, 1'b0, 1'b0, 1'b1, 3'b010));
        step(1'b1, bad_fn, 1'b0, 1'b0, es(0));

        // sub and slt funct decode
        step(1'b1, 32'h0022_1822, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, 32'h0022_1822, 1'b0, 1'b1, es(1));
        step(1'b1, 32'h0022_1822, 1'b0, 1'b1, e(6, 1'b0, 1'b0, 1'b0, 3'b110));
        step(1'b1, 32'h0022_1822, 1'b0, 1'b1, es(7));
        step(1'b1, 32'h0022_182A, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, 32'h0022_182A, 1'b0, 1'b1, es(1));
        step(1'b1, 32'h0022_182A, 1'b0, 1'b1, e(6, 1'b0, 1'b0, 1'b0, 3'b111));
        step(1'b1, 32'h0022_182A, 1'b0, 1'b1, es(7));

        // reset asserted while in LWWB aborts the write-back
        step(1'b1, lw_i, 1'b0, 1'b1, e(0, 1'b1, 1'b1, 1'b0, 3'b010));
        step(1'b1, lw_i, 1'b0, 1'b1, es(1));
        step(1'b1, lw_i, 1'b0, 1'b1, es(2));
        step(1'b1, lw_i, 1'b0, 1'b1, es(3));
        step(1'b0, lw_i, 1'b0, 1'b1, zr);
        step(1'b0, lw_i, 1'b0, 1'b1, zr);
        step(1'b1, lw_i, 1'b0, 1'b0, es(0));
        step(1'b1, lw_i, 1'b0, 1'b0, es(0));

        wait_cyc = 0;
        while (q_exp.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q_exp.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending entries required 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit that drives the shared-memory MIPS datapath. It reads the instruction register contents and the ALU zero flag back from the datapath and produces every datapath select and write-enable, plus the memory read and write strobes. Instruction fetch and data accesses wait on a memory-ready handshake, so memories with variable latency can sit behind the same port.

## Interface
- `WIDTH`, default 32: instruction width. `op` = `inst_i[WIDTH-1:WIDTH-6]`, `funct` = `inst_i[5:0]`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset. Reset is asynchronous and active-low.
- `inst_i`  in  WIDTH  current instruction-register value.
- `zero_i`  in  1  datapath ALU zero flag.
- `mem_ready_i`  in  1  memory has completed the current read or write this cycle.
- `memread_o`, `memwrite_o`  out  1  memory strobes.
- `alusrca_o`, `memtoreg_o`, `iord_o`, `regdst_o`  out  1 each  datapath selects.
- `pcen_o`, `regwrite_o`, `irwrite_o`  out  1 each  write enables.
- `pcsource_o`  out  2  next-PC select: 00 ALU result, 01 ALU-out register, 10 jump target.
- `alusrcb_o`  out  2  ALU B select: 00 register B, 01 constant 4, 10 immediate, 11 shifted offset.
- `alucont_o`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_o`  out  1  one-cycle pulse when an unsupported instruction is decoded.
- `state_o`  out  4  current state encoding, for debug.

## Operation
- **Supported opcodes:**
  - R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
  - R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- **Output defaults:** every output not listed for a state is 0. `alucont_o` defaults to 010 (add).
- **State encodings and actions:**
  - FETCH (0): `memread`=1, `alusrcb`=01. If `mem_ready_i`=1: `irwrite`=1 and `pcen`=1, then go to DECODE. Otherwise stay, with `irwrite` and `pcen` held at 0.
  - DECODE (1): `alusrcb`=11, which computes the branch target into the ALU-out register.
    - lw or sw → MEMADR; R-type with a legal funct → REX; addi → AEX; beq → BEX; j → JEX.
    - Anything else → FETCH with `illegal_o`=1.
  - MEMADR (2): `alusrca`=1, `alusrcb`=10. lw → LWRD; sw → SWWR.
  - LWRD (3): `iord`=1, `memread`=1. Go to LWWB when ready; otherwise stay.
  - LWWB (4): `regwrite`=1, `memtoreg`=1, `regdst`=0. → FETCH.
  - SWWR (5): `iord`=1, `memwrite`=1. Go to FETCH when ready; otherwise stay.
  - REX (6): `alusrca`=1, `alusrcb`=00, `alucont` decoded from funct. → RWB.
  - RWB (7): `regwrite`=1, `regdst`=1. → FETCH.
  - BEX (8): `alusrca`=1, `alusrcb`=00, `alucont`=110, `pcsource`=01, `pcen`=`zero_i`. → FETCH.
  - AEX (9): `alusrca`=1, `alusrcb`=10, add. → AWB.
  - AWB (10): `regwrite`=1, `regdst`=0. → FETCH.
  - JEX (11): `pcsource`=10, `pcen`=1. → FETCH.
- **Unused encodings 12–15:** go to FETCH on the next edge; all enables are 0 while there.
- **During a memory wait:** all strobes, selects and `iord` hold steady, so the memory address stays constant.

## Timing
- **Reset:**
  - While `rst`=0: the state is FETCH and every output is forced to 0, including `memread_o`, `state_o`=0 and `alucont_o`=000.
  - On the first edge after release, FETCH outputs apply combinationally: `memread_o`=1, `alusrcb_o`=01, `alucont_o`=010.
  - Reset asserted mid-instruction aborts that instruction immediately. No write enable is asserted during or after the abort.
- **Output timing:**
  - Outputs are Moore from the state register.
  - Three outputs have Mealy terms: `irwrite_o` and `pcen_o` in FETCH (on `mem_ready_i`), `pcen_o` in BEX (on `zero_i`), and `illegal_o` in DECODE (on `inst_i`).
- **Cycles per instruction with `mem_ready_i` tied to 1:** lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- **Added wait cycles:** each cycle that `mem_ready_i`=0 in FETCH, LWRD or SWWR adds exactly one cycle.
- **Ready in other states:** `mem_ready_i` is ignored outside FETCH, LWRD and SWWR.
- **DECODE decision:** uses the `inst_i` value present during DECODE, i.e. the IR loaded at the FETCH exit edge.

## Test plan
- **Reset:** hold `rst`=0 mid-way through LWWB → all outputs 0, `state_o`=0. Release → FETCH with `memread_o`=1, and no `regwrite_o` pulse ever occurs.
- **add with ready=1:** `inst_i`=0x00221820 → states 0,1,6,7,0. `alucont_o`=010 in REX; `regwrite_o`=1 and `regdst_o`=1 in RWB.
- **lw with memory waits:** `inst_i`=0x8C220004, `mem_ready_i` low for 2 cycles in LWRD → 7 total cycles. `iord_o`=1 held for 3 cycles; `memtoreg_o`=1 in LWWB.
- **beq both outcomes:** `inst_i`=0x10220003 with `zero_i`=1 → `pcen_o`=1 and `pcsource_o`=01 in BEX. Repeat with `zero_i`=0 → `pcen_o`=0.
- **j:** `inst_i`=0x08000010 → JEX asserts `pcen_o`=1 with `pcsource_o`=10, back to FETCH in 3 cycles.
- **Illegal instructions:**
  - op 111111 → `illegal_o` pulses for 1 cycle in DECODE, next state FETCH, no write enable asserted.
  - R-type funct 000111 → same behaviour.
